// File: rtl/tcb_pkg.sv
// rtl/tcb_pkg.sv - shared image geometry and packer state encoding for the TCB classifier
package tcb_pkg;

    localparam int N_PIX = 121;
    localparam int PIX_W = 8;
    localparam int IMG_W = N_PIX * PIX_W;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/tcb_img_packer.sv
// rtl/tcb_img_packer.sv - byte-serial pixel stream to flat image packer with SOF resync
module tcb_img_packer #(
    parameter int N_PIX = tcb_pkg::N_PIX,
    parameter int PIX_W = tcb_pkg::PIX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_W-1:0]       pix_data,
    input  logic                   pix_sof,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [N_PIX*PIX_W-1:0] img_source,
    output logic                   valid_top,
    input  logic                   ready_top,
    output logic [7:0]             drop_cnt,
    output logic                   busy
);

    import tcb_pkg::state_t;
    import tcb_pkg::ST_FILL;
    import tcb_pkg::ST_HOLD;

    localparam int IMG_W = N_PIX * PIX_W;
    localparam int CNT_W = $clog2(N_PIX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_PIX - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             beat;

    assign beat = pix_valid & pix_ready;
    assign busy = (cnt != '0) || (state == ST_HOLD);

    // FILL shifts pixels in and counts them; HOLD freezes the image until the classifier takes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_FILL;
            cnt        <= '0;
            img_source <= '0;
            valid_top  <= 1'b0;
            pix_ready  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    pix_ready <= 1'b1;
                    if (beat) begin
                        img_source <= {img_source[IMG_W-PIX_W-1:0], pix_data};
                        if (pix_sof && cnt != '0) begin
                            // A new frame started before the old one finished: restart at pixel 0.
                            // Leftover bytes of the old frame get shifted out by the new frame.
                            cnt <= CNT_W'(1);
                            if (drop_cnt != 8'hFF) begin
                                drop_cnt <= drop_cnt + 8'd1;
                            end
                        end else if (cnt == CNT_LAST) begin
                            cnt       <= '0;
                            state     <= ST_HOLD;
                            valid_top <= 1'b1;
                            pix_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (ready_top) begin
                        state     <= ST_FILL;
                        valid_top <= 1'b0;
                        pix_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcb_img_packer.sv
// tb/tb_tcb_img_packer.sv - self-checking bench for tcb_img_packer against a frame-level model
module tb_tcb_img_packer;

    localparam int NP = 121;
    localparam int IW = NP * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    pix_data = '0;
    logic          pix_sof = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [IW-1:0] img_source;
    logic          valid_top;
    logic          ready_top = 1'b0;
    logic [7:0]    drop_cnt;
    logic          busy;

    tcb_img_packer dut (
        .clk        (clk),
        .rst        (rst),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .img_source (img_source),
        .valid_top  (valid_top),
        .ready_top  (ready_top),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic prev_v = 1'b0;

    // frame-level model: pixels collected so far, holding flag, accept flag, drops, finished image
    logic [7:0]    q[$];
    logic          m_hold = 1'b0;
    logic          m_ready = 1'b0;
    int            m_drop = 0;
    logic [IW-1:0] m_img = '0;
    logic [IW-1:0] snap;

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic v, input logic s, input logic [7:0] d, input logic rt);
        if (m_hold) begin
            if (rt) begin
                m_hold  = 1'b0;
                m_ready = 1'b1;
            end
        end else begin
            if (m_ready && v) begin
                if (s && q.size() != 0) begin
                    if (m_drop < 255) m_drop++;
                    q.delete();
                end
                q.push_back(d);
                if (q.size() == NP) begin
                    for (int i = 0; i < NP; i++) m_img[IW-1-8*i -: 8] = q[i];
                    q.delete();
                    m_hold  = 1'b1;
                    m_ready = 1'b0;
                end else begin
                    m_ready = 1'b1;
                end
            end else begin
                m_ready = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] d, input logic rt);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        ready_top = rt;
        chk("pix_ready", IW'(pix_ready), IW'(m_ready));
        @(posedge clk);
        model_edge(v, s, d, rt);
        #1;
        chk("valid_top", IW'(valid_top), IW'(m_hold));
        chk("busy", IW'(busy), IW'(q.size() != 0 || m_hold));
        chk("drop_cnt", IW'(drop_cnt), IW'(m_drop));
        if (m_hold) chk("img_source", img_source, m_img);
        if (valid_top && !prev_v) pulses++;
        prev_v = valid_top;
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b0;
        pix_valid = 1'b1;
        pix_sof = 1'b1;
        pix_data = 8'h5A;
        ready_top = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_img", img_source, '0);
            chk("rst_valid", IW'(valid_top), '0);
            chk("rst_ready", IW'(pix_ready), '0);
            chk("rst_drop", IW'(drop_cnt), '0);
            chk("rst_busy", IW'(busy), '0);
        end
        q.delete();
        m_hold = 1'b0;
        m_ready = 1'b0;
        m_drop = 0;
        prev_v = 1'b0;
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ready_after_rst", IW'(pix_ready), IW'(1'b1));
    endtask

    initial begin
        // reset
        do_reset();

        // basic frame with handshake ready immediately
        for (int k = 0; k < NP; k++) step(1'b1, k == 0, 8'(k), 1'b1);
        chk("basic_first_byte", IW'(img_source[IW-1 -: 8]), IW'(8'h00));
        chk("basic_last_byte", IW'(img_source[7:0]), IW'(8'h78));
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        chk("basic_valid_clr", IW'(valid_top), '0);
        chk("basic_ready_set", IW'(pix_ready), IW'(1'b1));

        // backpressure: frame held for 20 cycles while the source keeps offering beats
        for (int k = 0; k < NP; k++) step(1'b1, k == 0, 8'($urandom), 1'b0);
        snap = img_source;
        for (int k = 0; k < 20; k++) step(1'b1, 1'($urandom), 8'($urandom), 1'b0);
        chk("bp_frozen", img_source, snap);
        chk("bp_valid", IW'(valid_top), IW'(1'b1));
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // resync: partial frame of 50, then SOF 0xAA and 120 more pixels
        for (int k = 0; k < 50; k++) step(1'b1, k == 0, 8'($urandom), 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("resync_drop", IW'(drop_cnt), IW'(8'd1));
        for (int k = 0; k < 120; k++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        chk("resync_valid", IW'(valid_top), IW'(1'b1));
        chk("resync_first", IW'(img_source[IW-1 -: 8]), IW'(8'hAA));
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // SOF on what would be the final beat resyncs instead of completing
        for (int k = 0; k < 120; k++) step(1'b1, k == 0, 8'($urandom), 1'b1);
        step(1'b1, 1'b1, 8'h3C, 1'b1);
        chk("sof_last_valid", IW'(valid_top), '0);
        chk("sof_last_drop", IW'(drop_cnt), IW'(8'd2));

        // drop saturation
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 1'b1, 8'($urandom), 1'b1);
            step(1'b1, 1'b0, 8'($urandom), 1'b1);
        end
        chk("sat_drop", IW'(drop_cnt), IW'(8'hFF));

        // reset while holding a finished frame, then one fresh frame of 0x11
        for (int k = 0; k < NP; k++) step(1'b1, k == 0, 8'($urandom), 1'b0);
        chk("pre_rst_hold", IW'(valid_top), IW'(1'b1));
        do_reset();
        pulses = 0;
        for (int k = 0; k < NP; k++) step(1'b1, k == 0, 8'h11, 1'b0);
        chk("fresh_img", img_source, {NP{8'h11}});
        step(1'b1, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("fresh_pulses", IW'(pulses), IW'(1));

        // randomized traffic against the model
        for (int k = 0; k < 2500; k++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 199) == 0,
                 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
